// File: rtl/vga_frame_grabber.sv
// VGA frame grabber: captures a pixel window of one frame into a FIFO.
// The host arms a capture, then drains pixel words over Avalon-MM.
module vga_frame_grabber #(
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int FIFO_AW  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic [7:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic [7:0]  VGA_R,
  input  logic [7:0]  VGA_G,
  input  logic [7:0]  VGA_B,
  input  logic        HSYNC,
  input  logic        VSYNC,
  input  logic        pix_en,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL =
    {1'b1, {FIFO_AW{1'b0}}};

  state_t r_state, w_state_n;
  logic r_hs_prev, r_vs_prev;
  logic [15:0] r_hcount, r_vcount;
  logic [15:0] w_hcnt, w_vcnt, w_x, w_y;
  logic [31:0] r_origin, r_size;
  logic [31:0] r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wp, r_rp;
  logic [FIFO_AW:0] r_level;
  logic r_ovf, r_irq;
  logic w_hs_rise, w_vs_rise;
  logic w_act_h, w_act_v, w_in_win, w_last;
  logic [16:0] w_x17, w_y17, w_xend, w_yend;
  logic w_ctrl_wr, w_clr, w_arm;
  logic w_push, w_pop, w_wr, w_empty, w_full;

  // Edges only count on strobe cycles, against the last strobed level.
  assign w_hs_rise = pix_en & HSYNC & ~r_hs_prev;
  assign w_vs_rise = pix_en & VSYNC & ~r_vs_prev;

  // Counter values that apply to the pixel strobed this cycle.
  assign w_hcnt = w_hs_rise ? 16'd0 :
                  (&r_hcount) ? r_hcount :
                  r_hcount + 16'd1;
  assign w_vcnt = w_vs_rise ? 16'd0 :
                  (w_hs_rise && !(&r_vcount)) ?
                  r_vcount + 16'd1 : r_vcount;

  assign w_act_h = (w_hcnt >= 16'(H_BP)) &&
    ({1'b0, w_hcnt} < 17'(H_BP + H_ACTIVE));
  assign w_act_v = (w_vcnt >= 16'(V_BP)) &&
    ({1'b0, w_vcnt} < 17'(V_BP + V_ACTIVE));
  assign w_x = w_hcnt - 16'(H_BP);
  assign w_y = w_vcnt - 16'(V_BP);

  // Window bounds are 17 bit so origin+size never wraps.
  assign w_x17  = {1'b0, w_x};
  assign w_y17  = {1'b0, w_y};
  assign w_xend = {1'b0, r_origin[15:0]} +
                  {1'b0, r_size[15:0]};
  assign w_yend = {1'b0, r_origin[31:16]} +
                  {1'b0, r_size[31:16]};
  assign w_in_win = pix_en & w_act_h & w_act_v &
    (w_x17 >= {1'b0, r_origin[15:0]}) &
    (w_x17 < w_xend) &
    (w_y17 >= {1'b0, r_origin[31:16]}) &
    (w_y17 < w_yend);
  assign w_last = (w_x17 + 17'd1 == w_xend) &&
                  (w_y17 + 17'd1 == w_yend);

  assign w_ctrl_wr = chipselect & write &
                     (address == 8'd0);
  assign w_clr = w_ctrl_wr & writedata[1];
  assign w_arm = w_ctrl_wr & writedata[0];

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == FULL_LVL);
  assign w_pop = chipselect & read &
                 (address == 8'd1) & ~w_empty;
  assign w_wr = w_push & (~w_full | w_pop);

  // Sync history and raster counters advance on strobes only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hs_prev <= 1'b1;
      r_vs_prev <= 1'b1;
      r_hcount  <= '0;
      r_vcount  <= '0;
    end else if (pix_en) begin
      r_hs_prev <= HSYNC;
      r_vs_prev <= VSYNC;
      r_hcount  <= w_hcnt;
      r_vcount  <= w_vcnt;
    end
  end

  // Capture FSM state register; irq mirrors entry into DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_irq   <= (w_state_n == S_DONE);
    end
  end

  // Next state and push decision; clear overrides everything.
  always_comb begin
    w_state_n = r_state;
    w_push    = 1'b0;
    unique case (r_state)
      S_IDLE:
        if (w_arm) w_state_n = S_ARMED;
      S_ARMED:
        if (w_vs_rise)
          w_state_n = (r_size[15:0] == 16'd0 ||
                       r_size[31:16] == 16'd0) ?
                      S_DONE : S_CAPTURE;
      S_CAPTURE:
        if (w_vs_rise) begin
          w_state_n = S_DONE;
        end else if (w_in_win) begin
          w_push = 1'b1;
          if (w_last) w_state_n = S_DONE;
        end
      S_DONE:
        if (w_arm) w_state_n = S_ARMED;
      default: w_state_n = S_IDLE;
    endcase
    if (w_clr) begin
      w_push    = 1'b0;
      w_state_n = w_arm ? S_ARMED : S_IDLE;
    end
  end

  // FIFO pointers, level and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else if (w_clr) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (w_wr && !w_pop)
        r_level <= r_level + 1'b1;
      else if (!w_wr && w_pop)
        r_level <= r_level - 1'b1;
      if (w_push && w_full && !w_pop)
        r_ovf <= 1'b1;
    end
  end

  // Pixel storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wp] <= {VGA_R, VGA_G, VGA_B, 8'h00};
  end

  // Window registers written by the host.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_origin <= '0;
      r_size   <= '0;
    end else if (chipselect && write) begin
      if (address == 8'd2) r_origin <= writedata;
      if (address == 8'd3) r_size   <= writedata;
    end
  end

  // Read mux, combinational from address.
  always_comb begin
    readdata = '0;
    case (address)
      8'd0: readdata = {16'(r_level), 11'd0, r_state,
                        r_ovf, w_full, w_empty};
      8'd1: readdata = w_empty ? 32'd0 : r_mem[r_rp];
      8'd2: readdata = r_origin;
      8'd3: readdata = r_size;
      default: readdata = '0;
    endcase
  end

  assign irq = r_irq;

endmodule

// File: tb/tb_vga_frame_grabber.sv
// Bench for vga_frame_grabber: random frames and bus traffic
// checked every cycle against a frame-level model.
module tb_vga_frame_grabber;

  localparam int HBP   = 4;
  localparam int HACT  = 16;
  localparam int VBP   = 2;
  localparam int VACT  = 6;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int NL    = VBP + VACT + 2;
  localparam logic [7:0] RD_PICK [8] =
    '{8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'hff};

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect, write, read;
  logic [7:0]  address;
  logic [31:0] writedata, readdata;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        HSYNC, VSYNC, pix_en, irq;

  always #5 clk = ~clk;

  vga_frame_grabber #(
    .H_BP(HBP), .H_ACTIVE(HACT), .V_BP(VBP),
    .V_ACTIVE(VACT), .FIFO_AW(AW)
  ) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect),
    .address(address), .write(write),
    .writedata(writedata), .read(read),
    .readdata(readdata), .VGA_R(VGA_R), .VGA_G(VGA_G),
    .VGA_B(VGA_B), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .pix_en(pix_en), .irq(irq)
  );

  int n_checks = 0;
  int n_err    = 0;
  int policy   = 0;
  int gapmax   = 0;
  int cmode    = 0;
  bit p_wr, p_rd;
  logic [7:0]  p_addr;
  logic [31:0] p_data;

  int mst;
  logic [31:0] mq[$];
  bit movf, mirq;
  logic [31:0] morg, msz;

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    mst = 0;
    mq.delete();
    movf = 0;
    mirq = 0;
    morg = '0;
    msz = '0;
  endtask

  function automatic logic [31:0] pat(int x, int y);
    return {8'(x), 8'(y), 8'(x ^ y), 8'h00};
  endfunction

  function automatic bit inwin(bit act, int x, int y);
    int x0, y0, w, h;
    x0 = int'(morg[15:0]);
    y0 = int'(morg[31:16]);
    w = int'(msz[15:0]);
    h = int'(msz[31:16]);
    return act && x >= x0 && x < x0 + w &&
           y >= y0 && y < y0 + h;
  endfunction

  function automatic bit islast(int x, int y);
    return x == int'(morg[15:0]) + int'(msz[15:0]) - 1 &&
           y == int'(morg[31:16]) + int'(msz[31:16]) - 1;
  endfunction

  function automatic logic [31:0] mread(logic [7:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      8'd0: v = {16'(mq.size()), 11'd0, 2'(mst), movf,
                 mq.size() == DEPTH, mq.size() == 0};
      8'd1: v = (mq.size() == 0) ? 32'd0 : mq[0];
      8'd2: v = morg;
      8'd3: v = msz;
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] rand_win(bit org);
    logic [15:0] a, b;
    if (org) begin
      a = 16'($urandom_range(0, HACT + 1));
      b = 16'($urandom_range(0, VACT + 1));
      if ($urandom_range(0, 9) == 0) a = 16'hfff0;
    end else begin
      a = 16'($urandom_range(0, HACT + 1));
      b = 16'($urandom_range(0, VACT));
      if ($urandom_range(0, 9) == 0) a = 16'hffff;
    end
    return {b, a};
  endfunction

  // One clock: drive, compare outputs, advance the model.
  task automatic tick(input bit pe, input bit hs,
                      input bit vs, input bit act,
                      input bit vsr, input int x,
                      input int y);
    int r, nxt;
    bit push, pop, clr, arm, wr;
    logic [31:0] pw;
    @(negedge clk);
    chipselect = 0; read = 0; write = 0;
    address = 0; writedata = 0;
    push = (mst == 2) && pe && !vsr && inwin(act, x, y);
    case (policy)
      1: begin
        r = $urandom_range(0, 99);
        if (r < 25) begin
          chipselect = 1; read = 1;
          address = RD_PICK[$urandom_range(0, 7)];
        end else if (r < 27) begin
          chipselect = 1; write = 1;
          address = (r == 25) ? 8'd2 : 8'd3;
          writedata = rand_win(r == 25);
        end else if (r == 27) begin
          chipselect = 1; write = 1; writedata = 1;
        end
      end
      2: if (push && mq.size() == DEPTH) begin
        chipselect = 1; read = 1; address = 1;
      end
      3: begin
        chipselect = 1; read = p_rd; write = p_wr;
        address = p_addr; writedata = p_data;
      end
      default: ;
    endcase
    pix_en = pe;
    HSYNC = pe ? hs : 1'($urandom);
    VSYNC = pe ? vs : 1'($urandom);
    if (pe && cmode == 0) begin
      VGA_R = 8'(x); VGA_G = 8'(y); VGA_B = 8'(x ^ y);
    end else begin
      {VGA_R, VGA_G, VGA_B} = 24'($urandom);
    end
    pw = {VGA_R, VGA_G, VGA_B, 8'h00};
    #1;
    chk("readdata", readdata, mread(address));
    chk("irq", {31'd0, irq}, {31'd0, mirq});
    wr = chipselect && write;
    clr = wr && address == 0 && writedata[1];
    arm = wr && address == 0 && writedata[0];
    pop = chipselect && read && address == 1 &&
          mq.size() > 0;
    if (clr) begin
      mq.delete();
      movf = 0;
      mirq = 0;
      mst = arm ? 1 : 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back(pw);
        else movf = 1;
      end
      nxt = mst;
      if (arm && (mst == 0 || mst == 3)) nxt = 1;
      else if (mst == 1 && vsr)
        nxt = (msz[15:0] == 0 || msz[31:16] == 0) ? 3 : 2;
      else if (mst == 2 && vsr) nxt = 3;
      else if (push && islast(x, y)) nxt = 3;
      if (nxt == 1 && mst != 1) mirq = 0;
      if (nxt == 3 && mst != 3) mirq = 1;
      mst = nxt;
    end
    if (wr && address == 2) morg = writedata;
    if (wr && address == 3) msz = writedata;
  endtask

  task automatic strobe(bit hs, bit vs, bit act, bit vsr,
                        int x, int y);
    int g;
    g = $urandom_range(0, gapmax);
    for (int i = 0; i < g; i++) tick(0, 0, 0, 0, 0, 0, 0);
    tick(1, hs, vs, act, vsr, x, y);
  endtask

  // Line j: strobe k after the HSYNC rise is column k-HBP.
  task automatic line(bit vpre, bit vpost, int j, bit vsr0);
    bit act;
    for (int i = 0; i < 3; i++) strobe(0, vpre, 0, 0, 0, 0);
    for (int k = 0; k < HBP + HACT + 3; k++) begin
      act = k >= HBP && k < HBP + HACT &&
            j >= VBP && j < VBP + VACT;
      strobe(1, vpost, act, k == 0 && vsr0,
             k - HBP, j - VBP);
    end
  endtask

  // VSYNC rises together with the HSYNC rise of line 0.
  task automatic frame(int nl);
    line(0, 0, -100, 0);
    line(0, 0, -100, 0);
    for (int j = 0; j < nl; j++) line(j != 0, 1, j, j == 0);
  endtask

  task automatic bus(bit wr, bit rd, logic [7:0] a,
                     logic [31:0] d);
    int sv;
    sv = policy;
    p_wr = wr; p_rd = rd; p_addr = a; p_data = d;
    policy = 3;
    tick(0, 0, 0, 0, 0, 0, 0);
    policy = sv;
  endtask

  task automatic status_is(string nm, logic [31:0] e);
    bus(0, 0, 8'd0, 0);
    chk(nm, readdata, e);
  endtask

  task automatic pop_is(string nm, logic [31:0] e);
    bus(0, 1, 8'd1, 0);
    chk(nm, readdata, e);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && mq.size() > 0; i++)
      bus(0, 1, 8'd1, 0);
    chk("drain_empty", 32'(mq.size()), 0);
  endtask

  initial begin
    reset = 1;
    chipselect = 0; read = 0; write = 0;
    address = 0; writedata = 0;
    pix_en = 0; HSYNC = 1; VSYNC = 1;
    VGA_R = 0; VGA_G = 0; VGA_B = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 0;

    status_is("reset_status", 32'h0000_0001);
    chk("reset_irq", {31'd0, irq}, 0);

    gapmax = 2;
    bus(1, 0, 8'd2, 32'd0);
    bus(1, 0, 8'd3, {16'd2, 16'd4});
    bus(1, 0, 8'd0, 32'd1);
    frame(NL);
    status_is("win4x2_status", 32'h0008_001a);
    chk("win4x2_irq", {31'd0, irq}, 1);
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++)
        pop_is("win4x2_pix", pat(x, y));
    status_is("win4x2_drained", 32'h0000_0019);

    bus(1, 0, 8'd3, {16'd1, 16'd16});
    bus(1, 0, 8'd0, 32'd1);
    frame(NL);
    status_is("ovf_status", 32'h0008_001e);
    for (int x = 0; x < 8; x++) pop_is("ovf_pix", pat(x, 0));
    status_is("ovf_drained", 32'h0000_001d);
    bus(1, 0, 8'd0, 32'd2);
    status_is("clear_status", 32'h0000_0001);

    bus(1, 0, 8'd3, 32'd0);
    bus(1, 0, 8'd0, 32'd1);
    status_is("zero_armed", 32'h0000_0009);
    frame(1);
    status_is("zero_done", 32'h0000_0019);
    chk("zero_irq", {31'd0, irq}, 1);
    bus(1, 0, 8'd0, 32'd3);
    status_is("clr_arm_status", 32'h0000_0009);
    chk("clr_arm_irq", {31'd0, irq}, 0);

    gapmax = 0;
    policy = 2;
    bus(1, 0, 8'd3, {16'd1, 16'd16});
    frame(NL);
    policy = 0;
    status_is("pushpop_status", 32'h0008_001a);
    for (int x = 8; x < 16; x++)
      pop_is("pushpop_pix", pat(x, 0));

    cmode = 1;
    gapmax = 2;
    bus(1, 0, 8'd3, {16'd6, 16'd16});
    bus(1, 0, 8'd0, 32'd1);
    frame(4);
    status_is("midcap_status", 32'h0008_0016);
    chipselect = 0; read = 0; write = 0; address = 0;
    #2 reset = 1;
    #1 chk("rst_status", readdata, 32'h0000_0001);
    chk("rst_irq", {31'd0, irq}, 0);
    address = 1;
    #1 chk("rst_data", readdata, 32'd0);
    model_reset();
    @(posedge clk);
    #2 reset = 0;

    for (int it = 0; it < 12; it++) begin
      bus(1, 0, 8'd2, rand_win(1));
      bus(1, 0, 8'd3, rand_win(0));
      bus(1, 0, 8'd0, (it % 4 == 3) ? 32'd3 : 32'd1);
      policy = 1;
      frame(NL);
      policy = 0;
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
